// File: rtl/snd_bus_seq_pkg.sv
// Shared types and defaults for the sound-chip bus sequencer: FSM states,
// request record layout and default strobe timing in fclk cycles.
package snd_bus_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 14;
  localparam int T_HOLD_DEF  = 4;

  // sel holds chip indices 0..4 (up to four YMs plus the SAA)
  localparam int REQ_DATA_W = 8;
  localparam int REQ_SEL_W  = 3;

  typedef struct packed {
    dir_e                  dir;
    logic                  a0;
    logic [REQ_DATA_W-1:0] data;
    logic [REQ_SEL_W-1:0]  sel;
  } req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snd_bus_seq_if.sv
// Host-side AY-slot bus: decoded single-cycle requests in, status and read data out.
interface snd_bus_seq_if #(
  parameter int SEL_W = 3
);
  logic             bus_wr;
  logic             bus_rd;
  logic             bus_a0;
  logic [7:0]       bus_din;
  logic [SEL_W-1:0] chip_sel;
  logic             busy;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             err;

  modport master (
    output bus_wr, bus_rd, bus_a0, bus_din, chip_sel,
    input  busy, rd_data, rd_valid, err
  );

  modport slave (
    input  bus_wr, bus_rd, bus_a0, bus_din, chip_sel,
    output busy, rd_data, rd_valid, err
  );
endinterface

// File: rtl/snd_strobe_timer.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module snd_strobe_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/snd_bus_seq.sv
// Sound-chip bus sequencer: turns host requests into timed CS/RD/WR/A0 strobes
// for NUM_YM YM chips and one write-only SAA1099, with a one-entry pending buffer.
module snd_bus_seq
  import snd_bus_seq_pkg::*;
#(
  parameter int NUM_YM  = 2,
  parameter int SEL_W   = 3,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  snd_bus_seq_if.slave      host,
  input  logic [7:0]        d_in,
  output logic [7:0]        d_out,
  output logic              d_oe,
  output logic [NUM_YM-1:0] ym_cs_n,
  output logic              ym_rd_n,
  output logic              ym_wr_n,
  output logic              ym_a0,
  output logic              saa_cs_n,
  output logic              saa_wr_n,
  output logic              saa_a0
);
  localparam int T_MAX = max3(T_SETUP, T_PULSE, T_HOLD);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [SEL_W-1:0]     SAA_SEL = SEL_W'(NUM_YM);
  localparam logic [REQ_SEL_W-1:0] SAA_IDX = REQ_SEL_W'(NUM_YM);
  localparam logic [NUM_YM-1:0]    YM_ONE  = NUM_YM'(1);

  state_e           state;
  req_t             pend;
  logic             pend_valid;
  dir_e             cur_dir;
  logic             cur_saa;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic             err_q;

  logic [SEL_W-1:0] sel_in;
  req_t             new_req;
  req_t             start_req;
  logic             req_any, req_ok, launch, direct, to_pend, drop;
  logic             start_valid, start_saa, start_saa_rd, start_seq;
  logic [NUM_YM-1:0] ym_cs_sel;
  logic             t_load, t_zero;
  logic [CNT_W-1:0] t_load_val;

  assign sel_in  = host.chip_sel;
  assign req_any = host.bus_wr | host.bus_rd;
  assign req_ok  = req_any & ~(host.bus_wr & host.bus_rd) & ~(sel_in > SAA_SEL);

  always_comb begin
    new_req      = '0;
    new_req.dir  = host.bus_rd ? DIR_RD : DIR_WR;
    new_req.a0   = host.bus_a0;
    new_req.data = host.bus_din;
    new_req.sel  = REQ_SEL_W'(sel_in);
  end

  // A full buffer that launches this edge can take a new request on the same edge
  assign launch  = (state == S_IDLE) & pend_valid;
  assign direct  = req_ok & (state == S_IDLE) & ~pend_valid;
  assign to_pend = req_ok & ~direct & (~pend_valid | launch);
  assign drop    = (req_any & ~req_ok) | (req_ok & ~direct & ~to_pend);

  assign start_valid  = launch | direct;
  assign start_req    = launch ? pend : new_req;
  assign start_saa    = (start_req.sel == SAA_IDX);
  assign start_saa_rd = start_saa & (start_req.dir == DIR_RD);
  assign start_seq    = start_valid & ~start_saa_rd;
  assign ym_cs_sel    = ~(YM_ONE << start_req.sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (to_pend) begin
      pend       <= new_req;
      pend_valid <= 1'b1;
    end else if (launch) begin
      pend_valid <= 1'b0;
    end
  end

  always_comb begin
    t_load     = 1'b0;
    t_load_val = '0;
    case (state)
      S_IDLE:  if (start_seq) begin t_load = 1'b1; t_load_val = CNT_W'(T_SETUP - 1); end
      S_SETUP: if (t_zero)    begin t_load = 1'b1; t_load_val = CNT_W'(T_PULSE - 1); end
      S_PULSE: if (t_zero)    begin t_load = 1'b1; t_load_val = CNT_W'(T_HOLD - 1);  end
      default: ;
    endcase
  end

  snd_strobe_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_dir    <= DIR_WR;
      cur_saa    <= 1'b0;
      ym_cs_n    <= '1;
      ym_rd_n    <= 1'b1;
      ym_wr_n    <= 1'b1;
      ym_a0      <= 1'b0;
      saa_cs_n   <= 1'b1;
      saa_wr_n   <= 1'b1;
      saa_a0     <= 1'b0;
      d_oe       <= 1'b0;
      d_out      <= '0;
      rd_data_q  <= 8'hFF;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= drop;
      case (state)
        S_IDLE: begin
          if (start_saa_rd && start_valid) begin
            rd_data_q  <= 8'hFF;
            rd_valid_q <= 1'b1;
          end else if (start_seq) begin
            state   <= S_SETUP;
            cur_dir <= start_req.dir;
            cur_saa <= start_saa;
            if (start_saa) begin
              saa_cs_n <= 1'b0;
              saa_a0   <= start_req.a0;
            end else begin
              ym_cs_n <= ym_cs_sel;
              ym_a0   <= start_req.a0;
            end
            d_oe  <= (start_req.dir == DIR_WR);
            d_out <= (start_req.dir == DIR_WR) ? start_req.data : '0;
          end
        end
        S_SETUP: if (t_zero) begin
          state <= S_PULSE;
          if (cur_saa)                 saa_wr_n <= 1'b0;
          else if (cur_dir == DIR_WR)  ym_wr_n  <= 1'b0;
          else                         ym_rd_n  <= 1'b0;
        end
        S_PULSE: if (t_zero) begin
          state    <= S_HOLD;
          ym_rd_n  <= 1'b1;
          ym_wr_n  <= 1'b1;
          saa_wr_n <= 1'b1;
          if (!cur_saa && cur_dir == DIR_RD) begin
            rd_data_q  <= d_in;
            rd_valid_q <= 1'b1;
          end
        end
        S_HOLD: if (t_zero) begin
          state    <= S_IDLE;
          ym_cs_n  <= '1;
          saa_cs_n <= 1'b1;
          ym_a0    <= 1'b0;
          saa_a0   <= 1'b0;
          d_oe     <= 1'b0;
          d_out    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.busy     = (state != S_IDLE) | pend_valid;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;
  assign host.err      = err_q;
endmodule

// File: tb/tb_snd_bus_seq.sv
// Directed bench for snd_bus_seq: default timing instance plus a T=1/1/1 instance.
module tb_snd_bus_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] d_in = 8'h00;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  snd_bus_seq_if #(.SEL_W(3)) bus0 ();
  snd_bus_seq_if #(.SEL_W(3)) bus1 ();

  logic [7:0] d_out0, d_out1;
  logic d_oe0, d_oe1;
  logic [1:0] ym_cs_n0, ym_cs_n1;
  logic ym_rd_n0, ym_wr_n0, ym_a00, saa_cs_n0, saa_wr_n0, saa_a00;
  logic ym_rd_n1, ym_wr_n1, ym_a01, saa_cs_n1, saa_wr_n1, saa_a01;

  snd_bus_seq #(.NUM_YM(2), .SEL_W(3), .T_SETUP(2), .T_PULSE(14), .T_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus0), .d_in(d_in), .d_out(d_out0), .d_oe(d_oe0),
    .ym_cs_n(ym_cs_n0), .ym_rd_n(ym_rd_n0), .ym_wr_n(ym_wr_n0), .ym_a0(ym_a00),
    .saa_cs_n(saa_cs_n0), .saa_wr_n(saa_wr_n0), .saa_a0(saa_a00)
  );

  snd_bus_seq #(.NUM_YM(2), .SEL_W(3), .T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(bus1), .d_in(d_in), .d_out(d_out1), .d_oe(d_oe1),
    .ym_cs_n(ym_cs_n1), .ym_rd_n(ym_rd_n1), .ym_wr_n(ym_wr_n1), .ym_a0(ym_a01),
    .saa_cs_n(saa_cs_n1), .saa_wr_n(saa_wr_n1), .saa_a0(saa_a01)
  );

  task automatic put_req(input logic wr, input logic rd, input logic a0,
                         input logic [7:0] din, input logic [2:0] sel);
    bus0.bus_wr = wr; bus0.bus_rd = rd; bus0.bus_a0 = a0;
    bus0.bus_din = din; bus0.chip_sel = sel;
  endtask

  task automatic put_req1(input logic wr, input logic [7:0] din, input logic [2:0] sel);
    bus1.bus_wr = wr; bus1.bus_rd = 1'b0; bus1.bus_a0 = 1'b0;
    bus1.bus_din = din; bus1.chip_sel = sel;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    repeat (2) @(negedge clk);
    obs = {ym_cs_n0, ym_rd_n0, ym_wr_n0, ym_a00, saa_cs_n0, saa_wr_n0, saa_a00,
           d_oe0, bus0.busy, bus0.rd_valid, bus0.err};
    n_checks++;
    if (obs !== 12'b11_1_1_0_1_1_0_0_0_0_0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected %b", obs, 12'b111101100000);
    end
    n_checks++;
    if (d_out0 !== 8'h00 || bus0.rd_data !== 8'hFF) begin
      n_fail++; $display("FAIL reset_data: d_out %h rd_data %h expected 00 FF", d_out0, bus0.rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ym_cs_n1 !== 2'b11 || saa_cs_n1 !== 1'b1 || bus1.busy !== 1'b0 || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: cs1 %b saa1 %b busy %b/%b expected 11 1 0/0",
                         ym_cs_n1, saa_cs_n1, bus0.busy, bus1.busy);
    end
  endtask

  task automatic test_ym_write();
    int cs_cnt, cs_first, wr_cnt, wr_first, bad, busy_cnt;
    cs_cnt = 0; cs_first = 0; wr_cnt = 0; wr_first = 0; bad = 0; busy_cnt = 0;
    put_req(1, 0, 1, 8'h5A, 3'd1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) put_req(0, 0, 0, 8'h00, 3'd0);
      if (ym_cs_n0 == 2'b01) begin
        cs_cnt++; if (cs_first == 0) cs_first = k;
        if (d_oe0 !== 1'b1 || d_out0 !== 8'h5A || ym_a00 !== 1'b1) bad++;
      end
      if (ym_wr_n0 == 1'b0) begin wr_cnt++; if (wr_first == 0) wr_first = k; end
      if (bus0.busy) busy_cnt++;
      if (saa_cs_n0 !== 1'b1 || ym_rd_n0 !== 1'b1) bad++;
    end
    n_checks++;
    if (cs_cnt != 20 || cs_first != 1) begin
      n_fail++; $display("FAIL wr_cs: len %0d first %0d expected 20 1", cs_cnt, cs_first);
    end
    n_checks++;
    if (wr_cnt != 14 || wr_first != 3) begin
      n_fail++; $display("FAIL wr_strobe: len %0d first %0d expected 14 3", wr_cnt, wr_first);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wr_bus_values: %0d bad cycles expected 0", bad); end
    n_checks++;
    if (busy_cnt != 20 || d_oe0 !== 1'b0 || ym_cs_n0 !== 2'b11) begin
      n_fail++; $display("FAIL wr_busy_end: busy %0d oe %b cs %b expected 20 0 11", busy_cnt, d_oe0, ym_cs_n0);
    end
  endtask

  task automatic test_ym_read();
    int rd_cnt, rd_first, cs_cnt, oe_cnt, rv_cnt, rv_k;
    logic [7:0] rv_data;
    rd_cnt = 0; rd_first = 0; cs_cnt = 0; oe_cnt = 0; rv_cnt = 0; rv_k = 0; rv_data = 8'h00;
    @(negedge clk);
    put_req(0, 1, 0, 8'h00, 3'd0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) put_req(0, 0, 0, 8'h00, 3'd0);
      if (ym_cs_n0 == 2'b10) cs_cnt++;
      if (ym_rd_n0 == 1'b0) begin rd_cnt++; if (rd_first == 0) rd_first = k; end
      if (d_oe0) oe_cnt++;
      if (bus0.rd_valid) begin rv_cnt++; rv_k = k; rv_data = bus0.rd_data; end
      d_in = (ym_rd_n0 == 1'b0) ? 8'hC3 : 8'h00;
    end
    n_checks++;
    if (rd_cnt != 14 || rd_first != 3 || cs_cnt != 20) begin
      n_fail++; $display("FAIL rd_strobe: rd %0d first %0d cs %0d expected 14 3 20", rd_cnt, rd_first, cs_cnt);
    end
    n_checks++;
    if (rv_cnt != 1 || rv_k != 17) begin
      n_fail++; $display("FAIL rd_valid_timing: pulses %0d at %0d expected 1 at 17", rv_cnt, rv_k);
    end
    n_checks++;
    if (rv_data !== 8'hC3 || oe_cnt != 0) begin
      n_fail++; $display("FAIL rd_data: got %h oe %0d expected C3 0", rv_data, oe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int falls, fall1, fall2, idle_between, err_cnt, err_k, wr_cnt, busy_low, d33;
    logic [1:0] pat1, pat2;
    logic [7:0] dat2;
    logic prev_low, cur_low;
    falls = 0; fall1 = 0; fall2 = 0; idle_between = 0; err_cnt = 0; err_k = 0;
    wr_cnt = 0; busy_low = 0; d33 = 0; pat1 = '0; pat2 = '0; dat2 = '0; prev_low = 1'b0;
    @(negedge clk);
    put_req(1, 0, 0, 8'h11, 3'd0);
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      cur_low = (ym_cs_n0 != 2'b11);
      if (cur_low && !prev_low) begin
        falls++;
        if (falls == 1) begin fall1 = k; pat1 = ym_cs_n0; end
        if (falls == 2) begin fall2 = k; pat2 = ym_cs_n0; dat2 = d_out0; end
      end
      if (!cur_low && falls == 1) idle_between++;
      prev_low = cur_low;
      if (bus0.err) begin err_cnt++; err_k = k; end
      if (ym_wr_n0 == 1'b0) wr_cnt++;
      if (d_out0 == 8'h33) d33++;
      if (!bus0.busy && busy_low == 0) busy_low = k;
      if (k == 1) put_req(1, 0, 0, 8'h22, 3'd1);
      if (k == 2) put_req(1, 0, 0, 8'h33, 3'd0);
      if (k == 3) put_req(0, 0, 0, 8'h00, 3'd0);
    end
    n_checks++;
    if (falls != 2 || fall1 != 1 || fall2 != 22 || pat1 !== 2'b10 || pat2 !== 2'b01) begin
      n_fail++; $display("FAIL b2b_order: falls %0d at %0d/%0d cs %b/%b expected 2 at 1/22 cs 10/01",
                         falls, fall1, fall2, pat1, pat2);
    end
    n_checks++;
    if (idle_between != 1 || dat2 !== 8'h22) begin
      n_fail++; $display("FAIL b2b_gap: idle %0d data %h expected 1 22", idle_between, dat2);
    end
    n_checks++;
    if (err_cnt != 1 || err_k != 3 || d33 != 0 || wr_cnt != 28) begin
      n_fail++; $display("FAIL b2b_drop: err %0d at %0d d33 %0d wr %0d expected 1 at 3 0 28",
                         err_cnt, err_k, d33, wr_cnt);
    end
    n_checks++;
    if (busy_low != 42) begin
      n_fail++; $display("FAIL b2b_busy: busy fell at %0d expected 42", busy_low);
    end
  endtask

  task automatic test_saa();
    int rv_cnt, strobe_cnt, cs_cnt, cs_first, wr_cnt, wr_first, bad;
    rv_cnt = 0; strobe_cnt = 0; cs_cnt = 0; cs_first = 0; wr_cnt = 0; wr_first = 0; bad = 0;
    @(negedge clk);
    put_req(0, 1, 0, 8'h00, 3'd2);
    @(negedge clk);
    put_req(0, 0, 0, 8'h00, 3'd0);
    n_checks++;
    if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 8'hFF || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL saa_read: valid %b data %h busy %b expected 1 FF 0",
                         bus0.rd_valid, bus0.rd_data, bus0.busy);
    end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (bus0.rd_valid) rv_cnt++;
      if (saa_cs_n0 !== 1'b1 || saa_wr_n0 !== 1'b1 || ym_cs_n0 !== 2'b11 || ym_rd_n0 !== 1'b1) strobe_cnt++;
    end
    n_checks++;
    if (rv_cnt != 0 || strobe_cnt != 0) begin
      n_fail++; $display("FAIL saa_read_quiet: extra valid %0d strobes %0d expected 0 0", rv_cnt, strobe_cnt);
    end
    put_req(1, 0, 1, 8'h77, 3'd2);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) put_req(0, 0, 0, 8'h00, 3'd0);
      if (saa_cs_n0 == 1'b0) begin
        cs_cnt++; if (cs_first == 0) cs_first = k;
        if (saa_a00 !== 1'b1 || d_out0 !== 8'h77 || d_oe0 !== 1'b1) bad++;
      end
      if (saa_wr_n0 == 1'b0) begin wr_cnt++; if (wr_first == 0) wr_first = k; end
      if (ym_cs_n0 !== 2'b11 || ym_wr_n0 !== 1'b1) bad++;
    end
    n_checks++;
    if (cs_cnt != 20 || cs_first != 1 || wr_cnt != 14 || wr_first != 3 || bad != 0) begin
      n_fail++; $display("FAIL saa_write: cs %0d@%0d wr %0d@%0d bad %0d expected 20@1 14@3 0",
                         cs_cnt, cs_first, wr_cnt, wr_first, bad);
    end
  endtask

  task automatic test_drop();
    int err_cnt, cs_cnt;
    err_cnt = 0; cs_cnt = 0;
    @(negedge clk);
    put_req(1, 0, 0, 8'h44, 3'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) put_req(0, 0, 0, 8'h00, 3'd0);
      if (bus0.err) err_cnt++;
      if (ym_cs_n0 !== 2'b11 || saa_cs_n0 !== 1'b1 || bus0.busy) cs_cnt++;
    end
    n_checks++;
    if (err_cnt != 1 || cs_cnt != 0) begin
      n_fail++; $display("FAIL drop_bad_sel: err %0d activity %0d expected 1 0", err_cnt, cs_cnt);
    end
    err_cnt = 0; cs_cnt = 0;
    put_req(1, 1, 0, 8'h44, 3'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) put_req(0, 0, 0, 8'h00, 3'd0);
      if (bus0.err) err_cnt++;
      if (ym_cs_n0 !== 2'b11 || saa_cs_n0 !== 1'b1 || bus0.busy) cs_cnt++;
    end
    n_checks++;
    if (err_cnt != 1 || cs_cnt != 0) begin
      n_fail++; $display("FAIL drop_rd_wr: err %0d activity %0d expected 1 0", err_cnt, cs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    act = 0;
    @(negedge clk);
    put_req(1, 0, 0, 8'h5A, 3'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) put_req(1, 0, 0, 8'h66, 3'd0);
      if (k == 2) put_req(0, 0, 0, 8'h00, 3'd0);
    end
    n_checks++;
    if (ym_wr_n0 !== 1'b0 || ym_cs_n0 !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_pulse: wr_n %b cs %b expected 0 01", ym_wr_n0, ym_cs_n0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ym_cs_n0 !== 2'b11 || ym_wr_n0 !== 1'b1 || d_oe0 !== 1'b0 || bus0.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: cs %b wr_n %b oe %b busy %b expected 11 1 0 0",
                         ym_cs_n0, ym_wr_n0, d_oe0, bus0.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ym_cs_n0 !== 2'b11 || saa_cs_n0 !== 1'b1 || bus0.busy !== 1'b0) act++;
    end
    n_checks++;
    if (act != 0) begin n_fail++; $display("FAIL rst_mid_stale: %0d active cycles expected 0", act); end
  endtask

  task automatic test_fast_timing();
    int falls, fall1, fall2, cs_cnt, idle_between, wr_cnt, wr_first;
    logic prev_low, cur_low;
    falls = 0; fall1 = 0; fall2 = 0; cs_cnt = 0; idle_between = 0; wr_cnt = 0; wr_first = 0;
    prev_low = 1'b0;
    @(negedge clk);
    put_req1(1, 8'hA1, 3'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) put_req1(1, 8'hB2, 3'd1);
      if (k == 2) put_req1(0, 8'h00, 3'd0);
      cur_low = (ym_cs_n1 != 2'b11);
      if (cur_low) cs_cnt++;
      if (cur_low && !prev_low) begin
        falls++;
        if (falls == 1) fall1 = k;
        if (falls == 2) fall2 = k;
      end
      if (!cur_low && falls == 1) idle_between++;
      prev_low = cur_low;
      if (ym_wr_n1 == 1'b0) begin wr_cnt++; if (wr_first == 0) wr_first = k; end
    end
    n_checks++;
    if (falls != 2 || fall1 != 1 || fall2 != 5 || cs_cnt != 6) begin
      n_fail++; $display("FAIL fast_cs: falls %0d at %0d/%0d low %0d expected 2 at 1/5 low 6",
                         falls, fall1, fall2, cs_cnt);
    end
    n_checks++;
    if (idle_between != 1 || wr_cnt != 2 || wr_first != 2) begin
      n_fail++; $display("FAIL fast_gap: idle %0d wr %0d first %0d expected 1 2 2",
                         idle_between, wr_cnt, wr_first);
    end
  endtask

  initial begin
    put_req(0, 0, 0, 8'h00, 3'd0);
    put_req1(0, 8'h00, 3'd0);
    test_reset();
    test_ym_write();
    test_ym_read();
    test_back_to_back();
    test_saa();
    test_drop();
    test_reset_mid();
    test_fast_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
